ex_exec_ctrl: RTL and testbench

//   Execute-stage sequencer. Accepts one operation per handshake from decode and sequences the

---
 rtl/ex_pkg.sv | 6 +
 rtl/ex_muldiv_iter.sv | 48 ++++
 rtl/ex_exec_ctrl.sv | 87 ++++++++
 tb/tb_ex_exec_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: op codes and FSM states shared by the execute-stage sequencer and its mul/div engine
package ex_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  typedef enum logic [2:0] {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU} md_op_e;
  typedef enum logic [1:0] {IDLE, MD_RUN, MD_FIX, DONE} state_e;
endpackage

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: unsigned shift-add multiply / restoring divide, one step per enabled cycle
module ex_muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            en,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            done_step
);
  localparam int CW = $clog2(ITERS);
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] dv, rsub;
  logic [XLEN:0] mul_sum, r;
  logic div_mode, ge;
  // hi:lo is product accumulator for mul, remainder:quotient for div
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
    r = {hi, lo[XLEN-1]};
    ge = r >= {1'b0, dv};
    rsub = r[XLEN-1:0] - dv;
    done_step = en && cnt == CW'(ITERS - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      dv <= '0;
      div_mode <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= a;
      dv <= b;
      div_mode <= is_div;
      cnt <= '0;
    end else if (en) begin
      {hi, lo} <= div_mode ? {ge ? rsub : r[XLEN-1:0], lo[XLEN-2:0], ge} : {mul_sum, lo[XLEN-1:1]};
      cnt <= done_step ? cnt : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ex_exec_ctrl.sv
// ex_exec_ctrl: execute-stage sequencer driving the single-cycle ALU and an iterative RV32M engine
module ex_exec_ctrl
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_md,
  input  logic [3:0]      in_alu_op,
  input  logic [2:0]      in_md_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            busy
);
  state_e state, state_nx;
  md_op_e md_op, op_in;
  logic accept, alu_go, load, done_step, sa, sb, neg;
  logic [XLEN-1:0] abs_a, abs_b, hi, lo, dv_sel, md_res;
  logic [2*XLEN-1:0] prod;
  always_comb begin
    op_in = md_op_e'(in_md_op);
    in_ready = !reset && !flush && (state == IDLE || (state == DONE && out_ready));
    accept = in_valid && in_ready;
    alu_go = accept && !in_is_md;
    load = accept && in_is_md;
    alu_op = alu_go ? in_alu_op : '0;
    alu_a = alu_go ? in_a : '0;
    alu_b = alu_go ? in_b : '0;
    sa = in_a[XLEN-1] && (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sb = in_b[XLEN-1] && (op_in inside {MD_MULH, MD_DIV, MD_REM});
    abs_a = sa ? -in_a : in_a;
    abs_b = sb ? -in_b : in_b;
    prod = neg ? -{hi, lo} : {hi, lo};
    dv_sel = (md_op inside {MD_DIV, MD_DIVU}) ? lo : hi;
    md_res = md_op[2] ? (neg ? -dv_sel : dv_sel) : md_op == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    busy = state == MD_RUN || state == MD_FIX;
    out_valid = state == DONE;
    state_nx = flush ? IDLE : accept ? (in_is_md ? MD_RUN : DONE) : (state == DONE && out_ready) ? IDLE :
               (state == MD_RUN && done_step) ? MD_FIX : state == MD_FIX ? DONE : state;
  end
  // divide by zero keeps the unsigned quotient of all ones, so its sign is never flipped
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      md_op <= MD_MUL;
      neg <= 1'b0;
      out_result <= '0;
      out_rd <= '0;
    end else begin
      state <= state_nx;
      if (accept) out_rd <= in_rd;
      if (alu_go) out_result <= alu_result;
      else if (state == MD_FIX) out_result <= md_res;
      if (load) begin
        md_op <= op_in;
        neg <= !in_md_op[2] ? sa ^ sb : in_md_op[1] ? sa : (sa ^ sb) && |in_b;
      end
    end
  end
  ex_muldiv_iter #(.XLEN(XLEN), .ITERS(ITERS)) u_iter (
    .clk(clk),
    .reset(reset),
    .load(load),
    .en(state == MD_RUN),
    .is_div(in_md_op[2]),
    .a(abs_a),
    .b(abs_b),
    .hi(hi),
    .lo(lo),
    .done_step(done_step)
  );
endmodule

// File: tb/tb_ex_exec_ctrl.sv
// tb_ex_exec_ctrl: directed stimulus checked every cycle against a transaction-level model
module tb_ex_exec_ctrl;
  import ex_pkg::*;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, in_is_md = 0, out_ready = 1;
  logic [3:0] in_alu_op = '0;
  logic [2:0] in_md_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [4:0] in_rd = '0;
  logic in_ready, out_valid, busy;
  logic [3:0] alu_op;
  logic [31:0] alu_a, alu_b, alu_result, out_result;
  logic [4:0] out_rd;
  int checks = 0, errors = 0;
  bit m_valid = 0, m_busy = 0, pr, acc;
  int m_left = 0;
  logic [31:0] m_res = '0, m_pend = '0;
  logic [4:0] m_rd = '0;
  localparam int N = 15;
  logic [2:0] t_op[N] = '{3, 0, 4, 6, 4, 6, 4, 6, 0, 1, 2, 5, 7, 6, 5};
  logic [31:0] t_a[N] = '{32'hffffffff, 32'hffffffff, 7, 7, 32'h80000000, 32'h80000000, 32'hfffffff9,
                          32'hfffffff9, 32'hfffffffd, 32'h80000000, 32'hffffffff, 100, 100, 7, 7};
  logic [31:0] t_b[N] = '{32'hffffffff, 32'hffffffff, 0, 0, 32'hffffffff, 32'hffffffff, 2, 2, 5,
                          32'h80000000, 32'hffffffff, 7, 7, 32'hfffffffe, 0};
  logic [31:0] t_e[N] = '{32'hfffffffe, 32'h00000001, 32'hffffffff, 7, 32'h80000000, 0, 32'hfffffffd,
                          32'hffffffff, 32'hfffffff1, 32'h40000000, 32'hffffffff, 14, 2, 1, 32'hffffffff};

  ex_exec_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_md(in_is_md), .in_alu_op(in_alu_op), .in_md_op(in_md_op), .in_a(in_a), .in_b(in_b),
    .in_rd(in_rd), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;
  assign alu_result = alu_op == ALU_ADD ? alu_a + alu_b : alu_a ^ alu_b;

  task automatic chk(input string n, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64, ub64;
    logic signed [31:0] sa32, sb32, q;
    logic [63:0] p;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub64 = {32'b0, b};
    sa32 = a;
    sb32 = b;
    p = '0;
    q = '0;
    case (op)
      0, 1: p = sa64 * sb64;
      2: p = sa64 * ub64;
      3: p = {32'b0, a} * {32'b0, b};
      default: ;
    endcase
    case (op)
      0: return p[31:0];
      1, 2, 3: return p[63:32];
      4: begin
        if (b == 0) return 32'hffffffff;
        if (a == 32'h80000000 && b == 32'hffffffff) return a;
        q = sa32 / sb32;
        return q;
      end
      5: return b == 0 ? 32'hffffffff : a / b;
      6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hffffffff) return 0;
        q = sa32 % sb32;
        return q;
      end
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  // every-cycle compare against the model, then advance the model with the inputs the next edge sees
  initial forever begin
    @(negedge clk);
    pr = !reset && !flush && !m_busy && (!m_valid || out_ready);
    acc = in_valid && pr;
    if (!reset) begin
      chk("in_ready", 72'(in_ready), 72'(pr));
      chk("out_valid", 72'(out_valid), 72'(m_valid));
      chk("busy", 72'(busy), 72'(m_busy));
      if (m_valid) chk("result_rd", 72'({out_result, out_rd}), 72'({m_res, m_rd}));
      chk("alu_drive", 72'({alu_op, alu_a, alu_b}), (acc && !in_is_md) ? 72'({in_alu_op, in_a, in_b}) : 72'(0));
    end
    if (reset || flush) begin
      m_valid = 0;
      m_busy = 0;
      if (reset) begin
        m_res = 0;
        m_rd = 0;
      end
    end else begin
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_valid = 1;
          m_res = m_pend;
        end
      end else if (m_valid && out_ready) m_valid = 0;
      if (acc) begin
        m_rd = in_rd;
        if (in_is_md) begin
          m_busy = 1;
          m_left = 33;
          m_pend = md_ref(in_md_op, in_a, in_b);
        end else begin
          m_valid = 1;
          m_res = in_alu_op == ALU_ADD ? in_a + in_b : in_a ^ in_b;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic md, input logic [3:0] ao, input logic [2:0] mo, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1;
    in_is_md = md;
    in_alu_op = ao;
    in_md_op = mo;
    in_a = a;
    in_b = b;
    in_rd = rd;
  endtask

  task automatic run_md(input logic [2:0] mo, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n, bc;
    send(1, 4'd0, mo, a, b, 5'd11);
    n = 0;
    bc = 0;
    sample();
    chk("md_accept", 72'(in_ready), 72'(1));
    do begin
      step();
      in_valid = 0;
      n++;
      sample();
      bc += int'(busy);
    end while (!out_valid && n < 60);
    chk("md_latency", 72'(n), 72'(34));
    chk("md_busy_cycles", 72'(bc), 72'(33));
    chk("md_result", 72'(out_result), 72'(exp));
    chk("md_rd", 72'(out_rd), 72'(11));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nv;
    repeat (2) step();
    reset = 0;
    step();
    sample();
    chk("rst_state", 72'({out_valid, busy, out_result, out_rd, alu_op}), 72'(0));
    chk("rst_in_ready", 72'(in_ready), 72'(1));
    step();
    send(0, ALU_ADD, 3'd0, 1, 1, 5'd3);
    sample();
    chk("add_alu_op", 72'(alu_op), 72'(4'b0100));
    step();
    in_valid = 0;
    sample();
    chk("add_result", 72'({out_valid, out_result, out_rd}), 72'({1'b1, 32'd2, 5'd3}));
    step();
    for (int i = 0; i < N; i++) run_md(t_op[i], t_a[i], t_b[i], t_e[i]);
    out_ready = 0;
    send(0, ALU_ADD, 3'd0, 10, 20, 5'd7);
    step();
    send(0, ALU_ADD, 3'd0, 1, 1, 5'd1);
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("bp_hold", 72'({out_valid, in_ready, out_result, out_rd}), 72'({1'b1, 1'b0, 32'd30, 5'd7}));
      step();
    end
    out_ready = 1;
    sample();
    chk("bp_release", 72'({in_ready, out_result}), 72'({1'b1, 32'd30}));
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k < 3) send(0, ALU_ADD, 3'd0, k + 1, k + 1, 5'(k + 1));
      else in_valid = 0;
      sample();
      chk("bp_stream", 72'({out_valid, out_result, out_rd}), 72'({1'b1, 32'(2 * k), 5'(k)}));
    end
    step();
    chk("bp_drain", 72'(out_valid), 72'(0));
    send(1, 4'd0, MD_DIVU, 100, 7, 5'd4);
    step();
    in_valid = 0;
    repeat (10) step();
    flush = 1;
    sample();
    chk("fl_busy_before", 72'({busy, in_ready}), 72'({1'b1, 1'b0}));
    step();
    flush = 0;
    sample();
    chk("fl_after", 72'({out_valid, busy, in_ready}), 72'({1'b0, 1'b0, 1'b1}));
    step();
    send(0, ALU_ADD, 3'd0, 2, 3, 5'd9);
    step();
    in_valid = 0;
    sample();
    chk("fl_add", 72'({out_valid, out_result, out_rd}), 72'({1'b1, 32'd5, 5'd9}));
    nv = 0;
    repeat (40) begin
      step();
      sample();
      nv += int'(out_valid);
    end
    chk("fl_no_result", 72'(nv), 72'(0));
    step();
    send(1, 4'd0, MD_MUL, 3, 5, 5'd6);
    step();
    in_valid = 0;
    repeat (10) step();
    reset = 1;
    step();
    reset = 0;
    sample();
    chk("rst_mid_outs", 72'({out_valid, busy, out_result, out_rd, alu_op, alu_a}), 72'(0));
    chk("rst_mid_ready", 72'(in_ready), 72'(1));
    repeat (40) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
